// File: rtl/dmem_arbiter_pkg.sv
// ============================================================================
// dmem_arbiter_pkg : shared state and read-owner encodings for dmem_arbiter
// Rev 1.0
// ============================================================================
`default_nettype none

package dmem_arbiter_pkg;

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_HALTED = 1'b1
  } arb_state_e;

  // Who issued the read whose data appears on dob this cycle
  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CORE = 2'd1,
    OWN_DBG  = 2'd2
  } owner_e;

endpackage

`default_nettype wire

// File: rtl/dmem_arbiter.sv
// ============================================================================
// dmem_arbiter : shares BRAM port B between the MEM stage and a debug/loader
//                requester, with starvation guard and debug halt mode
// Rev 1.0
// ============================================================================
`default_nettype none

module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int STARVE_MAX = 4,
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                core_req,
  input  logic [DATA_W/8-1:0] core_we,
  input  logic [ADDR_W-1:0]   core_addr,
  input  logic [DATA_W-1:0]   core_wdata,
  output logic                core_stall,
  output logic                core_rvalid,
  output logic [DATA_W-1:0]   core_rdata,
  input  logic                dbg_req,
  input  logic [DATA_W/8-1:0] dbg_we,
  input  logic [ADDR_W-1:0]   dbg_addr,
  input  logic [DATA_W-1:0]   dbg_wdata,
  output logic                dbg_gnt,
  output logic                dbg_rvalid,
  output logic [DATA_W-1:0]   dbg_rdata,
  input  logic                dbg_halt_req,
  output logic                dbg_halted,
  output logic [DATA_W/8-1:0] web,
  output logic [ADDR_W-1:0]   addrb,
  output logic [DATA_W-1:0]   dib,
  input  logic [DATA_W-1:0]   dob
);

  localparam int               CNT_W   = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

  arb_state_e        state_q, state_d;
  owner_e            owner_q, owner_d;
  logic [CNT_W-1:0]  starve_q, starve_d;
  logic [DATA_W-1:0] hold_q, hold_d;
  logic              core_issue;
  logic              dbg_issue;

  // Grant decision; everything is forced quiet while reset is asserted
  always_comb begin
    core_issue = 1'b0;
    dbg_issue  = 1'b0;
    core_stall = 1'b0;
    if (rst_n) begin
      if (state_q == ST_HALTED) begin
        core_stall = 1'b1;
        dbg_issue  = dbg_req;
      end else if (core_req && !(dbg_req && (starve_q == CNT_MAX))) begin
        core_issue = 1'b1;
      end else if (dbg_req) begin
        dbg_issue  = 1'b1;
        core_stall = core_req;
      end
    end
  end

  assign dbg_gnt = dbg_issue;
  assign addrb   = dbg_issue ? dbg_addr  : core_addr;
  assign dib     = dbg_issue ? dbg_wdata : core_wdata;
  assign web     = dbg_issue ? dbg_we : (core_issue ? core_we : '0);

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN:    if (dbg_halt_req)  state_d = ST_HALTED;
      ST_HALTED: if (!dbg_halt_req) state_d = ST_RUN;
      default:   state_d = ST_RUN;
    endcase

    starve_d = '0;
    if (dbg_req && !dbg_issue) begin
      starve_d = (starve_q == CNT_MAX) ? starve_q : starve_q + CNT_W'(1);
    end

    owner_d = OWN_NONE;
    if (core_issue && (core_we == '0)) begin
      owner_d = OWN_CORE;
    end else if (dbg_issue && (dbg_we == '0)) begin
      owner_d = OWN_DBG;
    end

    // Keeps the load word stable once dob moves on to another owner
    hold_d = core_rvalid ? dob : hold_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_RUN;
      owner_q  <= OWN_NONE;
      starve_q <= '0;
      hold_q   <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      starve_q <= starve_d;
      hold_q   <= hold_d;
    end
  end

  assign dbg_halted  = (state_q == ST_HALTED);
  assign core_rvalid = (owner_q == OWN_CORE);
  assign dbg_rvalid  = (owner_q == OWN_DBG);
  assign dbg_rdata   = dob;
  assign core_rdata  = core_rvalid ? dob : hold_q;

endmodule

`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
// ============================================================================
// tb_dmem_arbiter : scoreboard bench for dmem_arbiter with a BRAM port model
// Rev 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_dmem_arbiter;

  logic        clk;
  logic        rst_n;
  logic        core_req, dbg_req, dbg_halt_req;
  logic [3:0]  core_we, dbg_we, web;
  logic [31:0] core_addr, core_wdata, dbg_addr, dbg_wdata;
  logic        core_stall, core_rvalid, dbg_gnt, dbg_rvalid, dbg_halted;
  logic [31:0] core_rdata, dbg_rdata, addrb, dib, dob;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  typedef struct {
    int          due;
    logic [31:0] data;
  } exp_t;

  exp_t core_q[$];
  exp_t dbg_q[$];
  exp_t ce, de;

  dmem_arbiter #(.STARVE_MAX(4), .ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .core_req(core_req), .core_we(core_we), .core_addr(core_addr),
    .core_wdata(core_wdata), .core_stall(core_stall),
    .core_rvalid(core_rvalid), .core_rdata(core_rdata),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr),
    .dbg_wdata(dbg_wdata), .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid),
    .dbg_rdata(dbg_rdata), .dbg_halt_req(dbg_halt_req),
    .dbg_halted(dbg_halted), .web(web), .addrb(addrb), .dib(dib), .dob(dob)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // BRAM port B: read-first, one-cycle synchronous read, byte lanes
  logic [31:0] mem [0:63];
  logic        loaded = 1'b0;
  always @(posedge clk) begin
    if (!loaded) begin
      for (int i = 0; i < 64; i++) mem[i] <= 32'h0;
      mem[4]  <= 32'h12345678;
      mem[16] <= 32'h0000FFFF;
      mem[20] <= 32'hAAAA5555;
      loaded  <= 1'b1;
    end else begin
      for (int b = 0; b < 4; b++)
        if (web[b]) mem[addrb[7:2]][8*b +: 8] <= dib[8*b +: 8];
    end
    dob <= mem[addrb[7:2]];
  end

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic drive(input logic cr, input logic [3:0] cwe,
                       input logic [31:0] ca, input logic [31:0] cwd,
                       input logic dr, input logic [3:0] dwe,
                       input logic [31:0] da, input logic [31:0] dwd,
                       input logic halt);
    @(negedge clk);
    core_req = cr;  core_we = cwe; core_addr = ca; core_wdata = cwd;
    dbg_req  = dr;  dbg_we  = dwe; dbg_addr  = da; dbg_wdata  = dwd;
    dbg_halt_req = halt;
    #1;
  endtask

  task automatic idle(input logic halt);
    drive(1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0, halt);
  endtask

  // Read-return monitor: every returned word must match the queued expectation
  always @(posedge clk) begin
    #1;
    if (rst_n) begin
      if (core_q.size() > 0 && core_q[0].due < cyc) begin
        ce = core_q.pop_front();
        check("core_rvalid_missed", 32'd0, 32'd1);
      end
      if (core_q.size() > 0 && core_q[0].due == cyc) begin
        ce = core_q.pop_front();
        check("core_rvalid", {31'd0, core_rvalid}, 32'd1);
        check("core_rdata", core_rdata, ce.data);
      end else if (core_rvalid) begin
        check("core_rvalid_unexpected", 32'd1, 32'd0);
      end
      if (dbg_q.size() > 0 && dbg_q[0].due < cyc) begin
        de = dbg_q.pop_front();
        check("dbg_rvalid_missed", 32'd0, 32'd1);
      end
      if (dbg_q.size() > 0 && dbg_q[0].due == cyc) begin
        de = dbg_q.pop_front();
        check("dbg_rvalid", {31'd0, dbg_rvalid}, 32'd1);
        check("dbg_rdata", dbg_rdata, de.data);
      end else if (dbg_rvalid) begin
        check("dbg_rvalid_unexpected", 32'd1, 32'd0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    core_req = 1'b1; core_we = 4'hF; core_addr = 32'h10; core_wdata = 32'h1;
    dbg_req  = 1'b1; dbg_we  = 4'hF; dbg_addr  = 32'h20; dbg_wdata  = 32'h2;
    dbg_halt_req = 1'b0;

    // Requests during reset must be ignored
    #12;
    check("rst_web", {28'd0, web}, 32'd0);
    check("rst_core_stall", {31'd0, core_stall}, 32'd0);
    check("rst_dbg_gnt", {31'd0, dbg_gnt}, 32'd0);
    check("rst_core_rvalid", {31'd0, core_rvalid}, 32'd0);
    check("rst_dbg_rvalid", {31'd0, dbg_rvalid}, 32'd0);
    check("rst_dbg_halted", {31'd0, dbg_halted}, 32'd0);
    idle(1'b0);
    rst_n = 1'b1;
    idle(1'b0);

    // Core-only read
    drive(1'b1, 4'h0, 32'h10, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0);
    check("rd_addrb", addrb, 32'h10);
    check("rd_web", {28'd0, web}, 32'd0);
    check("rd_core_stall", {31'd0, core_stall}, 32'd0);
    core_q.push_back('{cyc + 1, 32'h12345678});
    idle(1'b0);

    // Debug write then read-back
    drive(1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 4'hF, 32'h20, 32'hDEADBEEF, 1'b0);
    check("dw_gnt", {31'd0, dbg_gnt}, 32'd1);
    check("dw_web", {28'd0, web}, 32'hF);
    check("dw_dib", dib, 32'hDEADBEEF);
    check("dw_addrb", addrb, 32'h20);
    drive(1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 4'h0, 32'h20, 32'h0, 1'b0);
    check("dr_gnt", {31'd0, dbg_gnt}, 32'd1);
    dbg_q.push_back('{cyc + 1, 32'hDEADBEEF});
    idle(1'b0);

    // Contention: debug forced a slot after four losses
    for (int i = 1; i <= 6; i++) begin
      drive(1'b1, 4'hF, 32'h30, 32'hCAFE0000 + i, 1'b1, 4'h0, 32'h40, 32'h0, 1'b0);
      if (i == 5) begin
        check("ct_gnt5", {31'd0, dbg_gnt}, 32'd1);
        check("ct_stall5", {31'd0, core_stall}, 32'd1);
        check("ct_addrb5", addrb, 32'h40);
        dbg_q.push_back('{cyc + 1, 32'h0000FFFF});
      end else begin
        check("ct_gnt", {31'd0, dbg_gnt}, 32'd0);
        check("ct_stall", {31'd0, core_stall}, 32'd0);
        check("ct_web", {28'd0, web}, 32'hF);
      end
    end
    idle(1'b0);

    // Core load word held while a debug read follows
    drive(1'b1, 4'h0, 32'h50, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0);
    core_q.push_back('{cyc + 1, 32'hAAAA5555});
    drive(1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 4'h0, 32'h40, 32'h0, 1'b0);
    check("hd_gnt", {31'd0, dbg_gnt}, 32'd1);
    dbg_q.push_back('{cyc + 1, 32'h0000FFFF});
    idle(1'b0);
    check("hd_core_rdata", core_rdata, 32'hAAAA5555);
    idle(1'b0);
    check("hd_core_rdata2", core_rdata, 32'hAAAA5555);

    // Halt mode with back-to-back debug writes
    idle(1'b1);
    check("ht_not_yet", {31'd0, dbg_halted}, 32'd0);
    idle(1'b1);
    check("ht_halted", {31'd0, dbg_halted}, 32'd1);
    check("ht_stall_noreq", {31'd0, core_stall}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 4'h0, 32'h10, 32'h0, 1'b1, 4'hF, 32'h60 + 4 * i,
            32'h11110000 + i, 1'b1);
      check("ht_gnt", {31'd0, dbg_gnt}, 32'd1);
      check("ht_web", {28'd0, web}, 32'hF);
      check("ht_stall", {31'd0, core_stall}, 32'd1);
      check("ht_addrb", addrb, 32'h60 + 4 * i);
    end
    drive(1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 4'h0, 32'h64, 32'h0, 1'b1);
    check("ht_rd_gnt", {31'd0, dbg_gnt}, 32'd1);
    dbg_q.push_back('{cyc + 1, 32'h11110001});
    drive(1'b1, 4'h0, 32'h10, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0);
    check("ht_still_halted", {31'd0, dbg_halted}, 32'd1);
    check("ht_still_stall", {31'd0, core_stall}, 32'd1);
    check("ht_no_issue", {28'd0, web}, 32'd0);
    drive(1'b1, 4'h0, 32'h10, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0);
    check("ht_resumed", {31'd0, dbg_halted}, 32'd0);
    check("ht_resume_stall", {31'd0, core_stall}, 32'd0);
    core_q.push_back('{cyc + 1, 32'h12345678});
    idle(1'b0);

    // Async reset while halted with a debug read returning
    idle(1'b1);
    drive(1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 4'h0, 32'h68, 32'h0, 1'b1);
    check("rs_halted", {31'd0, dbg_halted}, 32'd1);
    check("rs_gnt", {31'd0, dbg_gnt}, 32'd1);
    dbg_q.push_back('{cyc + 1, 32'h11110002});
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    dbg_halt_req = 1'b0;
    #1;
    check("rs_dbg_halted", {31'd0, dbg_halted}, 32'd0);
    check("rs_web", {28'd0, web}, 32'd0);
    check("rs_dbg_rvalid", {31'd0, dbg_rvalid}, 32'd0);
    check("rs_dbg_gnt", {31'd0, dbg_gnt}, 32'd0);
    check("rs_core_stall", {31'd0, core_stall}, 32'd0);
    drive(1'b1, 4'h0, 32'h10, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0);
    rst_n = 1'b1;
    #1;
    check("rs_run", {31'd0, dbg_halted}, 32'd0);
    check("rs_core_grant", {31'd0, core_stall}, 32'd0);
    check("rs_core_addrb", addrb, 32'h10);
    core_q.push_back('{cyc + 1, 32'h12345678});

    idle(1'b0);
    idle(1'b0);
    idle(1'b0);
    check("core_q_drained", core_q.size(), 32'd0);
    check("dbg_q_drained", dbg_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
